// File: rtl/arrow_key_conditioner.sv
// Arrow push-button front end: 2-flop sync, per-bit debounce, press queue and a one-hot event emitter.
// Build option ARROW_AUTOREPEAT_EN adds UP/DOWN auto-repeat; the default build has none.
module arrow_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] arrow_keys,
  output logic       key_event,
  output logic       busy
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int CTR_W = $clog2(HOLD_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} emit_state_t;

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("arrow_key_conditioner: timing parameters out of range");
  end

  function automatic logic [3:0] pick_key(input logic [3:0] req);
    pick_key = 4'b0000;
    if (req[3])      pick_key = 4'b1000;
    else if (req[2]) pick_key = 4'b0100;
    else if (req[1]) pick_key = 4'b0010;
    else if (req[0]) pick_key = 4'b0001;
  endfunction

  logic [3:0]      sync_p0;
  logic [3:0]      sync;
  logic [3:0]      stable;
  logic [3:0]      stable_d;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      press;
  logic [3:0]      rpt_set;
  logic [3:0]      press_set;
  logic [3:0]      pending;
  logic [3:0]      next_key;
  logic [CTR_W-1:0] ctr;
  emit_state_t     state;

  // Stage: synchroniser and debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      sync     <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync     <= sync_p0;
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

`ifdef ARROW_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_armed;
  logic [1:0]       rpt_fire;

  // Index 1 tracks UP (bit 3), index 0 tracks DOWN (bit 2); count starts the cycle the press is queued.
  always_comb begin
    rpt_fire = '0;
    for (int j = 0; j < 2; j++)
      rpt_fire[j] = stable[j+2] &&
                    (rpt_cnt[j] == (rpt_armed[j] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_armed <= '0;
      for (int j = 0; j < 2; j++) rpt_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!stable[j+2]) begin
          rpt_cnt[j]   <= '0;
          rpt_armed[j] <= 1'b0;
        end else if (rpt_fire[j]) begin
          rpt_cnt[j]   <= RPT_W'(1);
          rpt_armed[j] <= 1'b1;
        end else begin
          rpt_cnt[j]   <= rpt_cnt[j] + 1'b1;
        end
      end
    end
  end

  assign rpt_set = {rpt_fire, 2'b00};
`else
  assign rpt_set = 4'b0000;
`endif

  assign press_set = press | rpt_set;
  assign next_key  = pick_key(pending);

  // Stage: press queue and event emitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      ctr        <= '0;
      arrow_keys <= '0;
      key_event  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      key_event <= 1'b0;
      pending   <= pending | press_set;
      case (state)
        IDLE: begin
          if (pending != 4'b0000) begin
            arrow_keys <= next_key;
            key_event  <= 1'b1;
            busy       <= 1'b1;
            // A press landing on the selected bit this cycle keeps it queued.
            pending    <= (pending & ~next_key) | press_set;
            ctr        <= CTR_LOAD;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (ctr == '0) begin
            arrow_keys <= '0;
            ctr        <= CTR_LOAD;
            state      <= GAP;
          end else begin
            ctr <= ctr - 1'b1;
          end
        end
        GAP: begin
          if (ctr == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ctr <= ctr - 1'b1;
          end
        end
        default: begin
          arrow_keys <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
